memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
- Memory-side counterpart of the CPU request unit.
- Accepts instruction-fetch and data read/write requests (imemREN, dmemREN, dmemWEN).
- Serialises them onto a single RAM port and returns the ihit/dhit handshake and load data that the request unit and datapath consume.
- Sits between the datapath/request logic and the unified RAM model.

Parameters:
- ADDR_W, 32, width of all address buses.
- DATA_W, 32, width of all data buses.
- TIMEOUT, 64, maximum RAM wait cycles per access (used only with ARB_TIMEOUT_EN).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  instruction read request, held until ihit.
- imemaddr  input  ADDR_W  instruction address.
- dmemREN  input  1  data read request, held until dhit.
- dmemWEN  input  1  data write request, held until dhit.
- dmemaddr  input  ADDR_W  data address.
- dmemstore  input  DATA_W  write data.
- ihit  output  1  one-cycle pulse: instruction access complete.
- dhit  output  1  one-cycle pulse: data access complete.
- imemload  output  DATA_W  fetched instruction, valid while ihit=1.
- dmemload  output  DATA_W  read data, valid while dhit=1 (read only).
- ram_ren  output  1  RAM read enable.
- ram_wen  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_store  output  DATA_W  RAM write data.
- ram_load  input  DATA_W  RAM read data, valid when ram_rdy=1.
- ram_rdy  input  1  RAM access complete this cycle.
- err  output  1  sticky timeout flag (present only with ARB_TIMEOUT_EN).

Behaviour:
- One clock CLK; asynchronous active-low reset nRST.
- Reset values: all outputs 0, state IDLE, latches and counters 0. Assertion of nRST mid-access aborts immediately; no hit is issued for the aborted access.

FSM states: IDLE, DACC, IACC, DHIT, IHIT.
- IDLE: if dmemREN|dmemWEN -> DACC; else if imemREN -> IACC; else stay.
  - On leaving IDLE, latch address, store data and a write bit. dmemWEN=1 wins over dmemREN=1, so the access is a write.
  - Data always has priority over instruction when both are requested in the same cycle.
- DACC:
  - Outputs: ram_wen = latched write bit, ram_ren = ~write bit, ram_addr/ram_store = latched values.
  - If ram_rdy=1: capture ram_load into the dmemload register (reads only; dmemload holds its prior value on writes), then go to DHIT.
- IACC:
  - Outputs: ram_ren=1, ram_wen=0, ram_addr = latched imemaddr.
  - If ram_rdy=1: capture ram_load into imemload, then go to IHIT.
- DHIT: dhit=1 for exactly one cycle; ram_ren=ram_wen=0; go to IDLE.
- IHIT: ihit=1 for exactly one cycle; ram_ren=ram_wen=0; go to IDLE.
- ram_ren/ram_wen/ram_addr/ram_store are 0 in IDLE, DHIT and IHIT.
- Latency: request seen in IDLE at cycle 0; ram enables from cycle 1; with ram_rdy in cycle k>=1, the hit is asserted in cycle k+1. Minimum request-to-hit is 2 cycles.
- ihit and dhit are never both 1 in the same cycle. Only one RAM access is outstanding at a time.
- A request deasserted mid-access does not cancel it: the access completes and the hit still pulses.
- The request is sampled again only in IDLE, so a request still held during the hit cycle is not re-issued.
- Inputs are not re-sampled during DACC/IACC; latched values are used throughout.
- The ram_rdy value in IDLE/HIT states is ignored.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A wait counter, clog2(TIMEOUT+1) bits, clears on entering DACC/IACC and increments each ACC cycle without ram_rdy.
  - When the counter = TIMEOUT-1 and ram_rdy=0, the arbiter goes to the matching HIT state with load data 32'hBAD1BAD1 (imemload or dmemload) and sets err=1.
  - err is sticky until nRST.
- Undefined: no counter and no err port; DACC/IACC wait for ram_rdy indefinitely.

Test Plan:
- Reset: hold nRST=0 with random requests -> ihit=dhit=ram_ren=ram_wen=0, imemload=dmemload=0, ram_addr=0.
- Instruction fetch: imemREN=1, imemaddr=0x40; ram_rdy=1 on the 3rd IACC cycle with ram_load=0x8C220004 -> ram_ren=1 and ram_addr=0x40 for 3 cycles, then ihit=1 for 1 cycle with imemload=0x8C220004.
- Data write: dmemWEN=1, dmemaddr=0x100, dmemstore=0xDEADBEEF, ram_rdy=1 immediately -> ram_wen=1, ram_ren=0, ram_store=0xDEADBEEF; dhit in cycle 2.
- Contention: imemREN=dmemREN=1 in the same cycle, dmemaddr=0x200, imemaddr=0x44 -> the data access is served first and dhit pulses; then IDLE; then the instruction access runs and ihit pulses. The hits never overlap.
- Reset mid-access: deassert nRST during DACC -> all outputs 0 asynchronously; after release, state is IDLE and no dhit appears for the aborted access.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=4): dmemREN=1, ram_rdy held 0 -> dhit after 4 DACC cycles with dmemload=0xBAD1BAD1 and err=1, which stays 1 after later successful accesses.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Memory-side arbiter between the CPU request unit and a unified single-port
//   RAM. Instruction fetches and data reads/writes are serialised onto the RAM
//   port. Each one is acknowledged with a one-cycle ihit/dhit pulse, together
//   with the fetched instruction or the loaded data word.
//
//   Handshake: a requester raises imemREN / dmemREN / dmemWEN and holds it
//   until the matching hit pulse. A request is only sampled in IDLE. Once an
//   access starts, its address, store data and direction are held in registers
//   and the request inputs are ignored until the access finishes. On the RAM
//   side, the enables stay asserted until ram_rdy=1, which completes the
//   access in that cycle.
//
//   Optional feature (macro ARB_TIMEOUT_EN): a per-access wait counter ends
//   the access after TIMEOUT cycles without ram_rdy. The arbiter then returns
//   32'hBAD1BAD1 as the load data and sets the sticky err flag.
//
// Ports
//   CLK, nRST              clock (rising edge), asynchronous active-low reset
//   imemREN, imemaddr      instruction read request and address
//   dmemREN, dmemWEN       data read / write request (write wins if both)
//   dmemaddr, dmemstore    data address and write data
//   ihit, dhit             one-cycle completion pulses
//   imemload, dmemload     load data, valid while the matching hit is 1
//   ram_ren, ram_wen       RAM read / write enables
//   ram_addr, ram_store    RAM address and write data
//   ram_load, ram_rdy      RAM read data and access-complete strobe
//   err                    sticky timeout flag (ARB_TIMEOUT_EN only)
//   dbg_state              current FSM state for observation
module memory_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] imemload,
  output logic [DATA_W-1:0] dmemload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_rdy,
`ifdef ARB_TIMEOUT_EN
  output logic              err,
`endif
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DACC = 3'd1,
    IACC = 3'd2,
    DHIT = 3'd3,
    IHIT = 3'd4
  } state_t;

  state_t state;

  assign dbg_state = state;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] BAD_LOAD = DATA_W'(32'hBAD1BAD1);
  logic [CW-1:0] wait_cnt;
`endif

  // The RAM-side outputs are registered. During an access, ram_addr,
  // ram_store and ram_wen are the latched request itself. They are cleared
  // in every cycle that is not an access cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      imemload  <= '0;
      dmemload  <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt  <= '0;
      err       <= 1'b0;
`endif
    end else begin
      // Hit outputs are single-cycle pulses unless they are set again below.
      ihit <= 1'b0;
      dhit <= 1'b0;

      case (state)
        IDLE: begin
          if (dmemREN || dmemWEN) begin
            // Data is served before instructions. If both read and write
            // are requested, the access is a write.
            state     <= DACC;
            ram_wen   <= dmemWEN;
            ram_ren   <= ~dmemWEN;
            ram_addr  <= dmemaddr;
            ram_store <= dmemstore;
`ifdef ARB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end else if (imemREN) begin
            state     <= IACC;
            ram_ren   <= 1'b1;
            ram_wen   <= 1'b0;
            ram_addr  <= imemaddr;
            ram_store <= '0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end

        DACC: begin
          if (ram_rdy) begin
            // On a write, dmemload keeps the last read value.
            if (!ram_wen) begin
              dmemload <= ram_load;
            end
            state     <= DHIT;
            dhit      <= 1'b1;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            dmemload  <= BAD_LOAD;
            err       <= 1'b1;
            state     <= DHIT;
            dhit      <= 1'b1;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        IACC: begin
          if (ram_rdy) begin
            imemload  <= ram_load;
            state     <= IHIT;
            ihit      <= 1'b1;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            imemload  <= BAD_LOAD;
            err       <= 1'b1;
            state     <= IHIT;
            ihit      <= 1'b1;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        // A request still held during the hit cycle is ignored here. It is
        // sampled again only after the return to IDLE.
        DHIT:    state <= IDLE;
        IHIT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
